// File: rtl/serial_transmitter.sv
// Frame-level serial transmitter: start bit, DATA_BITS payload bits LSB-first, stop bit.
// Bit time set by CLKS_PER_BIT; all outputs registered so the line never glitches.
//
// state | meaning
// IDLE  | line high, Ready=1, waiting for Load
// START | start bit (0) on the line for one bit time
// DATA  | payload bit shiftReg[0] on the line, bitIdx selects position
// STOP  | stop bit (1) on the line, Done in its last cycle
module serial_transmitter #(
   parameter int CLKS_PER_BIT = 16,
   parameter int DATA_BITS    = 8
) (
   input  logic                 CLK,
   input  logic                 RST_N,
   input  logic [DATA_BITS-1:0] DataIN,
   input  logic                 Load,
   output logic                 Ready,
   output logic                 SerialOUT,
   output logic                 Busy,
   output logic                 Done
);

   localparam int CNT_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam int IDX_W = (DATA_BITS > 1) ? $clog2(DATA_BITS) : 1;
   localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(CLKS_PER_BIT - 1);
   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(DATA_BITS - 1);
   // With a one-cycle bit time the first stop cycle is also the last one.
   localparam logic DONE_ON_ENTRY = (CLKS_PER_BIT == 1);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      START = 2'd1,
      DATA  = 2'd2,
      STOP  = 2'd3
   } txState_e;

   txState_e             state;
   logic [CNT_W-1:0]     bitCnt;
   logic [IDX_W-1:0]     bitIdx;
   logic [DATA_BITS-1:0] shiftReg;

   logic                 bitEnd;
   logic [CNT_W-1:0]     cntInc;
   logic [DATA_BITS-1:0] shiftNext;

   assign bitEnd    = (bitCnt == LAST_CNT);
   assign cntInc    = bitCnt + CNT_W'(1);
   assign shiftNext = shiftReg >> 1;

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         state     <= IDLE;
         bitCnt    <= '0;
         bitIdx    <= '0;
         shiftReg  <= '0;
         SerialOUT <= 1'b1;
         Busy      <= 1'b0;
         Ready     <= 1'b1;
         Done      <= 1'b0;
      end else begin
         Done <= 1'b0;
         case (state)
            IDLE: begin
               bitCnt <= '0;
               bitIdx <= '0;
               if (Load && Ready) begin
                  shiftReg  <= DataIN;
                  SerialOUT <= 1'b0;
                  Busy      <= 1'b1;
                  Ready     <= 1'b0;
                  state     <= START;
               end
            end

            START: begin
               if (bitEnd) begin
                  bitCnt    <= '0;
                  SerialOUT <= shiftReg[0];
                  state     <= DATA;
               end else begin
                  bitCnt <= cntInc;
               end
            end

            DATA: begin
               if (bitEnd) begin
                  bitCnt   <= '0;
                  shiftReg <= shiftNext;
                  if (bitIdx == LAST_IDX) begin
                     bitIdx    <= '0;
                     SerialOUT <= 1'b1;
                     Done      <= DONE_ON_ENTRY;
                     state     <= STOP;
                  end else begin
                     bitIdx    <= bitIdx + IDX_W'(1);
                     SerialOUT <= shiftNext[0];
                  end
               end else begin
                  bitCnt <= cntInc;
               end
            end

            STOP: begin
               if (bitEnd) begin
                  bitCnt    <= '0;
                  SerialOUT <= 1'b1;
                  Busy      <= 1'b0;
                  Ready     <= 1'b1;
                  state     <= IDLE;
               end else begin
                  bitCnt <= cntInc;
                  // Registered, so raise it one edge ahead of the final stop cycle.
                  Done   <= (cntInc == LAST_CNT);
               end
            end

            default: begin
               state     <= IDLE;
               SerialOUT <= 1'b1;
               Busy      <= 1'b0;
               Ready     <= 1'b1;
            end
         endcase
      end
   end

endmodule

// File: doc/serial_transmitter.md
# serial_transmitter

Frame-level serial transmitter that pairs with `SerialReceiver`. It accepts an 8-bit parallel word through a valid/ready handshake and serializes it LSB-first onto a single line. Each frame is 10 bits: one start bit (0), eight data bits, and one stop bit (1). That is the same 10-bit frame the receiver presents on its parallel output. A programmable divider sets the bit time.

## Interface

Parameters:
- `CLKS_PER_BIT`, default 16. Number of `CLK` cycles each bit is held on the line. Legal range is 1 to 65535.
- `DATA_BITS`, default 8. Number of payload bits. The frame length is `DATA_BITS`+2.

Ports:
- `CLK`  input  1  system clock. All logic is on the rising edge.
- `RST_N`  input  1  asynchronous, active-low reset. One clock; reset is asynchronous and active-low.
- `DataIN`  input  `DATA_BITS`  payload word. Sampled only on the accepting edge.
- `Load`  input  1  payload valid.
- `Ready`  output  1  block can accept a word.
- `SerialOUT`  output  1  serial line. Idle level is 1.
- `Busy`  output  1  a frame is in progress.
- `Done`  output  1  one-cycle pulse when a frame completes.

## Operation

- **Reset values:** `SerialOUT`=1, `Ready`=1, `Busy`=0, `Done`=0. State is IDLE, and all counters and the shift register are cleared.
- **State machine:** IDLE → START → DATA → STOP → IDLE.
- **IDLE:**
  - `Ready`=1 and `SerialOUT`=1.
  - Acceptance occurs on a rising edge where `Load`=1 and `Ready`=1.
  - On acceptance, `DataIN` is latched into the shift register and the state moves to START.
- **START:** `SerialOUT`=0 for `CLKS_PER_BIT` cycles, then the state moves to DATA.
- **DATA:**
  - `SerialOUT` = shift register bit 0.
  - Each bit is held for `CLKS_PER_BIT` cycles. The register then shifts right and the bit index increments.
  - After bit `DATA_BITS`-1, the state moves to STOP.
- **STOP:**
  - `SerialOUT`=1 for `CLKS_PER_BIT` cycles.
  - `Done`=1 during the last of those cycles.
  - The state then moves to IDLE.
- **Busy and Ready:** `Busy`=1 in START, DATA and STOP. `Ready` is exactly the inverse of `Busy`.
- **Counters:**
  - The bit-time counter is wide enough for `CLKS_PER_BIT`-1. It counts 0 to `CLKS_PER_BIT`-1 and wraps to 0 on each bit boundary.
  - The bit index is wide enough for `DATA_BITS`-1.
- **`SerialOUT` is registered.** It never glitches, and it never depends combinationally on `DataIN` or `Load`.
- **Boundary conditions:**
  - `Load` while `Busy`=1 is ignored. No queuing takes place, and the in-flight frame is unaffected.
  - Changes on `DataIN` after acceptance have no effect on the current frame.
  - `Load` held high continuously produces back-to-back frames, with exactly 1 idle-high cycle (the IDLE acceptance cycle) between a stop bit and the next start bit.
  - With `CLKS_PER_BIT`=1, each bit lasts one cycle and the frame is 10 cycles.
  - When `RST_N` is asserted mid-frame, outputs return to their reset values immediately (asynchronously) and the frame is aborted. The stop bit is not completed.
  - On `RST_N` deassertion, the first acceptance is possible on the first rising edge after release.

## Timing

- **Acceptance edge:** call the edge where `Load`&`Ready`=1 edge E0.
- **Start bit:** `SerialOUT` goes 0 and `Busy` goes 1 after E0, for cycles 0 to C-1 relative to E0, where C=`CLKS_PER_BIT`.
- **Data bit i:** occupies cycles C·(1+i) to C·(2+i)-1.
- **Stop bit:** occupies cycles C·(DATA_BITS+1) to C·(DATA_BITS+2)-1. `Done`=1 only in the last of these cycles.
- **Return to idle:** `Ready`=1 and `Busy`=0 from cycle C·(DATA_BITS+2).
- **Throughput:** the frame lasts C·(DATA_BITS+2) cycles. The minimum repetition period is C·(DATA_BITS+2)+1 cycles.
- **Latency:** 1 edge from acceptance to the start bit.

## Test plan

1. **Reset levels.** Hold `RST_N`=0 for 5 cycles, then release. Required: `SerialOUT`=1, `Ready`=1, `Busy`=0, `Done`=0 throughout, and nothing transmits with `Load`=0.
2. **Single frame.** With C=4, send `DataIN`=0xA5. Required line sequence, each bit for 4 cycles: 0,1,0,1,0,0,1,0,1,1. `Busy` is high for 40 cycles, `Done` pulses for 1 cycle at cycle 39, and `Ready` returns at cycle 40.
3. **Ignored load and data hold.** Send 0x3C. Mid-frame, assert `Load` with `DataIN`=0xFF. Required: the line still carries 0,0,0,1,1,1,1,0,0,1, and no second frame follows.
4. **Back-to-back frames.** Hold `Load`=1 and send 0x00 then 0xFF with C=2. Required: two 20-cycle frames separated by exactly 1 high cycle, and two `Done` pulses 21 cycles apart.
5. **Abort.** Drop `RST_N` during data bit 3 of 0x55, asynchronously between edges. Required: `SerialOUT`=1, `Busy`=0 and `Ready`=1 immediately. After release, a new 0x81 frame transmits correctly.
6. **Minimum bit time.** Send 0x01 with C=1. Required: 0,1,0,0,0,0,0,0,0,1 in 10 consecutive cycles, with `Done` in the 10th.
